// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: master 0 is the parked default owner, a hold counter
// bounds contested tenure, and the slave read data is muxed by the registered select.
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [7:0]  m0_address,
  input  logic [31:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [7:0]  m1_address,
  input  logic [31:0] m1_dout,
  input  logic [4:0]  s_sel,
  input  logic [31:0] s0_dout,
  input  logic [31:0] s1_dout,
  input  logic [31:0] s2_dout,
  input  logic [31:0] s3_dout,
  input  logic [31:0] s4_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        s_wr,
  output logic [7:0]  s_address,
  output logic [31:0] s_din,
  output logic [31:0] m_din
);

  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_hold_cnt;
  logic [7:0]  w_hold_next;
  logic [4:0]  r_sel_d;
  logic        w_own_m1;
  logic        w_other_req;
  logic        w_hold_done;

  assign w_own_m1    = (r_state == M1_GRANT);
  assign w_other_req = w_own_m1 ? m0_req : m1_req;
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= M0_GRANT;
      r_hold_cnt <= 8'd0;
      r_sel_d    <= 5'd0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_sel_d    <= s_sel;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    case (r_state)
      M0_GRANT: begin
        if (m1_req && (!m0_req || w_hold_done))
          w_state_next = M1_GRANT;
      end
      M1_GRANT: begin
        // An idle master 1 always hands the bus back to the parking owner.
        if (!m1_req || (m0_req && w_hold_done))
          w_state_next = M0_GRANT;
      end
      default: w_state_next = M0_GRANT;
    endcase
    if ((w_state_next != r_state) || !w_other_req)
      w_hold_next = 8'd0;
    else if (!w_hold_done)
      w_hold_next = r_hold_cnt + 8'd1;
  end

  assign m0_grant  = (r_state == M0_GRANT);
  assign m1_grant  = w_own_m1;
  assign s_address = w_own_m1 ? m1_address : m0_address;
  assign s_din     = w_own_m1 ? m1_dout : m0_dout;
  assign s_wr      = w_own_m1 ? (m1_req & m1_wr) : (m0_req & m0_wr);

  // Select bits are ordered {s0..s4}, so slave k sits at bit 4-k.
  logic [31:0] w_slv_dout [5];
  logic [31:0] w_masked   [5];
  logic [31:0] w_rd_or;
  logic        w_sel_onehot;

  assign w_slv_dout[0] = s0_dout;
  assign w_slv_dout[1] = s1_dout;
  assign w_slv_dout[2] = s2_dout;
  assign w_slv_dout[3] = s3_dout;
  assign w_slv_dout[4] = s4_dout;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_rd
      assign w_masked[gi] = r_sel_d[4-gi] ? w_slv_dout[gi] : 32'h0000_0000;
    end
  endgenerate

  always_comb begin
    w_rd_or = 32'h0000_0000;
    for (int i = 0; i < 5; i++)
      w_rd_or = w_rd_or | w_masked[i];
  end

  assign w_sel_onehot = (r_sel_d != 5'd0) && ((r_sel_d & (r_sel_d - 5'd1)) == 5'd0);
  assign m_din        = w_sel_onehot ? w_rd_or : 32'h0000_0000;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: fixed vector table, hand-written multi-cycle corners,
// and randomized traffic checked against an ownership/streak reference model.
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int MAX_HOLD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout;
  logic [4:0]  s_sel;
  logic [31:0] s0_dout, s1_dout, s2_dout, s3_dout, s4_dout;
  logic        m0_grant, m1_grant, s_wr;
  logic [7:0]  s_address;
  logic [31:0] s_din, m_din;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .s_sel(s_sel),
    .s0_dout(s0_dout), .s1_dout(s1_dout), .s2_dout(s2_dout), .s3_dout(s3_dout), .s4_dout(s4_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .s_wr(s_wr),
    .s_address(s_address), .s_din(s_din), .m_din(m_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: who owns the bus, how many contested cycles it has held it,
  // and which slave was selected on the previous clock.
  int         mdl_owner;
  int         mdl_streak;
  logic [4:0] mdl_sel_d;

  function automatic logic [31:0] mdl_rd(input logic [4:0] sel);
    logic [31:0] douts [5];
    douts[0] = s0_dout; douts[1] = s1_dout; douts[2] = s2_dout;
    douts[3] = s3_dout; douts[4] = s4_dout;
    if ($countones(sel) != 1) return 32'h0;
    for (int b = 0; b < 5; b++)
      if (sel[b]) return douts[4-b];
    return 32'h0;
  endfunction

  task automatic mdl_step();
    logic own_req, oth_req, give;
    own_req = (mdl_owner == 1) ? m1_req : m0_req;
    oth_req = (mdl_owner == 1) ? m0_req : m1_req;
    give = 1'b0;
    if (mdl_owner == 1 && !m1_req) give = 1'b1;
    else if (mdl_owner == 0 && !m0_req && m1_req) give = 1'b1;
    else if (own_req && oth_req) begin
      mdl_streak++;
      if (mdl_streak >= MAX_HOLD) give = 1'b1;
    end else mdl_streak = 0;
    if (give) begin
      mdl_owner  = 1 - mdl_owner;
      mdl_streak = 0;
    end
    mdl_sel_d = s_sel;
  endtask

  task automatic mdl_check_cycle(input int idx);
    logic [31:0] e_din;
    logic [7:0]  e_addr;
    logic        e_wr;
    #1;
    e_addr = (mdl_owner == 1) ? m1_address : m0_address;
    e_din  = (mdl_owner == 1) ? m1_dout : m0_dout;
    e_wr   = (mdl_owner == 1) ? (m1_req & m1_wr) : (m0_req & m0_wr);
    chk($sformatf("rnd%0d grants", idx), {30'd0, m1_grant, m0_grant},
        (mdl_owner == 1) ? 32'd2 : 32'd1);
    chk($sformatf("rnd%0d s_wr", idx), {31'd0, s_wr}, {31'd0, e_wr});
    chk($sformatf("rnd%0d s_address", idx), {24'd0, s_address}, {24'd0, e_addr});
    chk($sformatf("rnd%0d s_din", idx), s_din, e_din);
    chk($sformatf("rnd%0d m_din", idx), m_din, mdl_rd(mdl_sel_d));
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  typedef struct {
    logic        r0, w0, r1, w1;
    logic [4:0]  sel;
    logic        e_m0g, e_swr;
    logic [7:0]  e_addr;
    logic [31:0] e_din, e_mdin;
  } vec_t;

  vec_t tbl [8];
  int   run;

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_address = 8'h00; m0_dout = 32'h0;
    m1_req = 0; m1_wr = 0; m1_address = 8'h00; m1_dout = 32'h0;
    s_sel = 5'd0;
    s0_dout = 32'hA0; s1_dout = 32'hB1; s2_dout = 32'hC2; s3_dout = 32'hD3; s4_dout = 32'hE4;

    //               r0    w0    r1    w1    sel       m0g   swr   addr   din            mdin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b0, 8'h10, 32'h1111_1111, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b10000, 1'b1, 1'b1, 8'h10, 32'h1111_1111, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00001, 1'b1, 1'b0, 8'h10, 32'h1111_1111, 32'hA0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00011, 1'b0, 1'b1, 8'h25, 32'hA5A5_A5A5, 32'hE4};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b00100, 1'b0, 1'b1, 8'h25, 32'hA5A5_A5A5, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b01000, 1'b0, 1'b0, 8'h25, 32'hA5A5_A5A5, 32'hC2};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b0, 8'h10, 32'h1111_1111, 32'hB1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b0, 8'h10, 32'h1111_1111, 32'h0};

    // Reset state with no requests.
    do_reset();
    #1;
    chk("reset grants", {30'd0, m1_grant, m0_grant}, 32'd1);
    chk("reset s_wr", {31'd0, s_wr}, 32'd0);
    chk("reset m_din", m_din, 32'h0);
    #1;
    m0_address = 8'h10; m0_dout = 32'h1111_1111;
    m1_address = 8'h25; m1_dout = 32'hA5A5_A5A5;
    @(posedge clk); #1;

    // Vector table.
    for (int v = 0; v < 8; v++) begin
      m0_req = tbl[v].r0; m0_wr = tbl[v].w0;
      m1_req = tbl[v].r1; m1_wr = tbl[v].w1;
      s_sel  = tbl[v].sel;
      #1;
      chk($sformatf("vec%0d grants", v), {30'd0, m1_grant, m0_grant},
          {30'd0, ~tbl[v].e_m0g, tbl[v].e_m0g});
      chk($sformatf("vec%0d s_wr", v), {31'd0, s_wr}, {31'd0, tbl[v].e_swr});
      chk($sformatf("vec%0d s_address", v), {24'd0, s_address}, {24'd0, tbl[v].e_addr});
      chk($sformatf("vec%0d s_din", v), s_din, tbl[v].e_din);
      chk($sformatf("vec%0d m_din", v), m_din, tbl[v].e_mdin);
      tick();
    end

    // Both masters requesting continuously: 16-cycle alternating tenure from M1.
    do_reset();
    m0_req = 0; m1_req = 1; m1_wr = 0; s_sel = 5'd0;
    tick();
    m0_req = 1;
    for (int c = 0; c < 64; c++) begin
      #1;
      chk($sformatf("alt c%0d m1_grant", c), {31'd0, m1_grant},
          (((c / 16) % 2) == 0) ? 32'd1 : 32'd0);
      tick();
    end

    // Master 0 read: data appears one cycle after the address/select.
    do_reset();
    m1_req = 0; m0_req = 1; m0_wr = 0; m0_address = 8'h45;
    s_sel = 5'b00010; s3_dout = 32'h1234_5678;
    #1;
    chk("read s_address", {24'd0, s_address}, 32'h45);
    chk("read m_din before", m_din, 32'h0);
    tick();
    chk("read m_din after", m_din, 32'h1234_5678);

    // Master 1 drops its request: bus parks on master 0 even if master 0 is idle.
    m0_req = 0; m0_wr = 1; m1_req = 1; m1_wr = 1;
    tick();
    chk("drop pre m1_grant", {31'd0, m1_grant}, 32'd1);
    m1_req = 0;
    tick();
    chk("drop m0_grant", {31'd0, m0_grant}, 32'd1);
    chk("drop s_wr", {31'd0, s_wr}, 32'd0);

    // Asynchronous reset during master 1 tenure, then hold count restarts.
    m0_req = 1; m0_wr = 0; m1_req = 1; m1_wr = 1;
    s_sel = 5'b10000; s0_dout = 32'hCAFE_0001;
    tick();
    m0_req = 0;
    tick();
    m0_req = 1;
    repeat (5) tick();
    chk("arst pre m1_grant", {31'd0, m1_grant}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst m0_grant", {31'd0, m0_grant}, 32'd1);
    chk("arst m1_grant", {31'd0, m1_grant}, 32'd0);
    chk("arst s_wr", {31'd0, s_wr}, 32'd0);
    chk("arst m_din", m_din, 32'h0);
    #1;
    reset = 1'b0;
    run = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m0_grant !== 1'b1) break;
      run++;
    end
    chk("arst m0 tenure", run, MAX_HOLD);

    // Randomized traffic against the reference model.
    do_reset();
    mdl_owner = 0; mdl_streak = 0; mdl_sel_d = 5'd0;
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
      m0_wr = 1'($urandom); m1_wr = 1'($urandom);
      m0_address = 8'($urandom); m1_address = 8'($urandom);
      m0_dout = $urandom; m1_dout = $urandom;
      s_sel = ($urandom_range(0, 3) == 0) ? 5'($urandom) : (5'd1 << $urandom_range(0, 4));
      s0_dout = $urandom; s1_dout = $urandom; s2_dout = $urandom;
      s3_dout = $urandom; s4_dout = $urandom;
      mdl_check_cycle(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, max consecutive granted cycles for one master while the other master requests (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: m0_req  input  1  bus request, master 0 (host/testbench).
REQ-005 Port: m0_wr  input  1  master 0 write enable (1=write, 0=read).
REQ-006 Port: m0_address  input  8  master 0 address.
REQ-007 Port: m0_dout  input  32  master 0 write data.
REQ-008 Port: m1_req, m1_wr, m1_address, m1_dout  input  1/1/8/32  same meanings, master 1 (DMAC).
REQ-009 Port: s_sel  input  5  one-hot slave select {s0..s4} from the address decoder, driven from s_address.
REQ-010 Port: s0_dout..s4_dout  input  32 each  slave read data (DMAC regs, multiplier regs, RAM x3).
REQ-011 Port: m0_grant, m1_grant  output  1 each  bus ownership, exactly one high at all times.
REQ-012 Port: s_wr  output  1  write enable to slaves, taken from the granted master.
REQ-013 Port: s_address  output  8  address to decoder/slaves, taken from the granted master.
REQ-014 Port: s_din  output  32  write data to slaves, taken from the granted master.
REQ-015 Port: m_din  output  32  read data returned to both masters.

Function
REQ-016 FSM states SHALL be M0_GRANT and M1_GRANT; m0_grant=1 iff state==M0_GRANT, m1_grant=1 iff state==M1_GRANT (Moore, registered).
REQ-017 In M0_GRANT: m0_req=0 and m1_req=1 -> M1_GRANT; m0_req=1, m1_req=1, hold_cnt==MAX_HOLD-1 -> M1_GRANT; otherwise stay.
REQ-018 In M1_GRANT: m1_req=0 -> M0_GRANT (park on master 0, regardless of m0_req); m1_req=1, m0_req=1, hold_cnt==MAX_HOLD-1 -> M0_GRANT; otherwise stay.
REQ-019 hold_cnt (8-bit) SHALL clear to 0 on every state change and in any cycle the other master's req is 0; otherwise increment by 1, saturating at MAX_HOLD-1.
REQ-020 Grant changes take effect the cycle after the deciding edge (1-cycle arbitration latency); no combinational path from req to grant.
REQ-021 s_wr, s_address, s_din SHALL be combinational muxes selected by the current grant; the non-granted master's inputs SHALL have no effect.
REQ-022 s_wr SHALL be forced to 0 when the granted master's req is 0, preventing writes from a parked, idle owner.
REQ-023 sel_d (5-bit register) SHALL capture s_sel every clock; m_din = sN_dout for the single set bit of sel_d (1-cycle read latency matching synchronous RAM).
REQ-024 sel_d == 0 or more than one bit set -> m_din = 32'h0000_0000.
REQ-025 Simultaneous first requests from idle (both req rising same cycle while parked in M0_GRANT) -> master 0 keeps the bus.
REQ-026 A requester dropping req in the same cycle the hold limit expires -> the normal drop rule (REQ-017/018) applies; result is identical.

Reset
REQ-027 reset=1 SHALL immediately force state=M0_GRANT, hold_cnt=0, sel_d=0, so m0_grant=1, m1_grant=0, m_din=0, regardless of clk.
REQ-028 Reset asserted mid-transfer SHALL abort the ownership of master 1 with no further s_wr from master 1; after release arbitration restarts from M0_GRANT with hold_cnt=0.

Verification
REQ-029 Reset release, both req=0 -> m0_grant=1, m1_grant=0, s_wr=0, m_din=0.
REQ-030 m1_req=1 alone, m1_address=8'h25, m1_wr=1, m1_dout=32'hA5A5A5A5 -> m1_grant=1 after 1 clk; s_address=8'h25, s_din=32'hA5A5A5A5, s_wr=1.
REQ-031 Both req held high with MAX_HOLD=16, starting in M1_GRANT -> m1_grant for exactly 16 cycles, then m0_grant for 16 cycles, alternating.
REQ-032 Master 0 read at 8'h45 (s_sel=5'b00010), s3_dout=32'h1234_5678 -> m_din=32'h1234_5678 one cycle after the address is presented, 0 before.
REQ-033 m1_grant=1, m1_req falls -> m0_grant=1 next cycle even with m0_req=0; s_wr=0.
REQ-034 reset pulsed asynchronously mid-cycle during M1_GRANT -> m0_grant=1 before next clk edge; hold_cnt restarts at 0.
